data_bus_responder: RTL
=======================

# data_bus_responder

Responder for the processor's single-cycle data port (we, a, wd, rd), replacing the plain data RAM in `top`. It decodes each access into a word RAM or one of three memory-mapped registers: an output FIFO, a status register and a cycle counter. The FIFO drains to the bench or a downstream consumer through a valid/ready stream. Reads stay combinational, so the processor's single-cycle timing is unchanged.

## Interface
- RAM_WORDS, 64, number of 32-bit RAM words, mapped at byte 0x000 upward
- FIFO_DEPTH, 8, output FIFO entries; power of two, minimum 2
- IO_BASE, 32'h0000_0800, byte base of the register block; must lie above the RAM region
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high
- we  input  1  write strobe from the processor (MemWrite)
- a  input  32  byte address (DataAdr); a[1:0] ignored
- wd  input  32  write data (WriteData)
- rd  output  32  read data (ReadData), combinational
- out_valid  output  1  FIFO head valid
- out_data  output  32  FIFO head word
- out_ready  input  1  consumer accepts head this cycle
- err  output  1  registered one-cycle error pulse

## Operation
- Decode uses word index w = a[31:2]:
  - w < RAM_WORDS: RAM.
  - IO_BASE+0x0: TXDATA.
  - IO_BASE+0x4: STATUS.
  - IO_BASE+0x8: CYCLES.
  - Anything else: unmapped.
- RAM: read returns RAM[w]. Write stores wd at the clock edge. RAM contents are not reset.
- TXDATA:
  - Write pushes wd into the FIFO.
  - Read returns 0.
  - The push is accepted if count < FIFO_DEPTH, or if a pop happens in the same cycle.
  - Otherwise the word is dropped, overflow is set and err pulses.
- STATUS read returns:
  - bit0 empty, bit1 full, bit2 overflow (sticky).
  - bits[15:8] count, zero-extended.
  - All other bits 0.
- STATUS write: wd[2]=1 clears overflow. Other bits are ignored.
- If an overflow and a clear occur in the same cycle, overflow ends up set.
- CYCLES:
  - Free-running 32-bit counter, +1 every cycle, wraps 0xFFFF_FFFF -> 0.
  - Read returns its current value.
  - Write loads 0 and takes precedence over the increment.
- Unmapped read returns 0. Unmapped write is discarded and err pulses.
- Stream side:
  - out_valid = ~empty; out_data = head entry.
  - Pop when out_valid & out_ready.
  - out_data must stay stable while out_valid & ~out_ready.
- FIFO pointers wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH.

## Timing
- Reset values:
  - rd reflects the decode (RAM contents undefined).
  - out_valid 0, out_data 0, err 0.
  - count 0, overflow 0, CYCLES 0, FIFO pointers 0.
- Read latency 0: rd settles combinationally from a within the same cycle.
- Write and push take effect at the rising edge where we=1.
- A word pushed at edge N makes out_valid=1 after edge N, when the FIFO was empty.
- Pop takes effect at the edge where out_valid & out_ready.
- Push and pop in the same cycle leave count unchanged. Push while full with a pop is accepted.
- err is asserted the cycle after the offending edge, for exactly one cycle.
- Reset asserted mid-operation: all state returns to reset values immediately; in-flight FIFO data is lost.

## Structure
- Package bus_map_pkg:
  - register offsets TXDATA_OFS=0x0, STATUS_OFS=0x4, CYCLES_OFS=0x8
  - STATUS bit positions (EMPTY_B=0, FULL_B=1, OVF_B=2, COUNT_LSB=8)
  - decode enum {REG_RAM, REG_TX, REG_STATUS, REG_CYCLES, REG_NONE}
- Sub-module sync_fifo holds the FIFO:
  - parameters WIDTH, DEPTH
  - ports push, pop, din, dout, count, full, empty
- Top level holds the address decode, RAM, overflow flag, cycle counter and err register.

## Test plan
- Reset, then write 0x1234 to byte 0x10 and read it back -> rd=0x1234 in the same cycle as the read; STATUS reads 0x0000_0001.
- out_ready=0, push 0xA0..0xA7 -> STATUS=0x0000_0802. A 9th push of 0xA8 -> err pulse 1 cycle, STATUS=0x0000_0806. Drain -> out_data sequence 0xA0..0xA7, 0xA8 never appears.
- FIFO full, push 0xB0 with out_ready=1 in the same cycle -> no err, count stays 8, 0xB0 later emerges last.
- Write STATUS with wd=0x4 -> overflow clears, STATUS bit2=0. Write to 0x0000_0900 -> err pulse, then read 0x900 -> rd=0.
- Write CYCLES at cycle k, read 5 cycles later -> rd=5. Force the counter to 0xFFFF_FFFF -> next value 0.
- Push 3 words, assert reset mid-drain -> out_valid=0 and STATUS=0x0000_0001 immediately. After release, a new push appears at out_data with no stale data.

Source files
------------

// File: rtl/bus_map_pkg.sv
// Register map and decode types for the processor data-port responder.
package bus_map_pkg;

    localparam logic [31:0] TXDATA_OFS = 32'h0;
    localparam logic [31:0] STATUS_OFS = 32'h4;
    localparam logic [31:0] CYCLES_OFS = 32'h8;

    localparam int EMPTY_B   = 0;
    localparam int FULL_B    = 1;
    localparam int OVF_B     = 2;
    localparam int COUNT_LSB = 8;

    typedef enum logic [2:0] {
        REG_RAM,
        REG_TX,
        REG_STATUS,
        REG_CYCLES,
        REG_NONE
    } reg_sel_e;

    function automatic logic [31:0] status_word(
        input logic       empty,
        input logic       full,
        input logic       ovf,
        input logic [7:0] count
    );
        logic [31:0] s;
        s = '0;
        s[EMPTY_B] = empty;
        s[FULL_B]  = full;
        s[OVF_B]   = ovf;
        s[COUNT_LSB +: 8] = count;
        return s;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO is taken only alongside a pop.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    // Gate the head so the stream output reads 0 while empty.
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/data_bus_responder.sv
// Data-port responder: word RAM plus TXDATA/STATUS/CYCLES registers, combinational reads.
module data_bus_responder
    import bus_map_pkg::*;
#(
    parameter int          RAM_WORDS  = 64,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] IO_BASE    = 32'h0000_0800
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        out_valid,
    output logic [31:0] out_data,
    input  logic        out_ready,
    output logic        err
);

    localparam int          RAM_AW    = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam int          CW        = $clog2(FIFO_DEPTH + 1);
    localparam logic [29:0] RAM_LIMIT = 30'(RAM_WORDS);
    localparam logic [31:0] TX_ADR    = IO_BASE + TXDATA_OFS;
    localparam logic [31:0] ST_ADR    = IO_BASE + STATUS_OFS;
    localparam logic [31:0] CY_ADR    = IO_BASE + CYCLES_OFS;
    localparam logic [29:0] TX_W      = TX_ADR[31:2];
    localparam logic [29:0] ST_W      = ST_ADR[31:2];
    localparam logic [29:0] CY_W      = CY_ADR[31:2];

    logic [29:0]       w;
    logic [RAM_AW-1:0] ram_idx;
    reg_sel_e          sel;
    logic [31:0]       ram [RAM_WORDS];

    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          tx_push;
    logic          pop;
    logic          push_ok;
    logic          ovf_event;
    logic          ovf_clear;
    logic          err_next;
    logic          overflow;
    logic [31:0]   cycles;
    logic          unused_addr_lsbs;

    assign w                = a[31:2];
    assign ram_idx          = w[RAM_AW-1:0];
    assign unused_addr_lsbs = ^a[1:0];

    always_comb begin
        sel = REG_NONE;
        if (w < RAM_LIMIT) begin
            sel = REG_RAM;
        end else if (w == TX_W) begin
            sel = REG_TX;
        end else if (w == ST_W) begin
            sel = REG_STATUS;
        end else if (w == CY_W) begin
            sel = REG_CYCLES;
        end
    end

    always_ff @(posedge clk) begin
        if (we && sel == REG_RAM) begin
            ram[ram_idx] <= wd;
        end
    end

    always_comb begin
        rd = '0;
        case (sel)
            REG_RAM:    rd = ram[ram_idx];
            REG_STATUS: rd = status_word(fifo_empty, fifo_full, overflow, 8'(fifo_count));
            REG_CYCLES: rd = cycles;
            default:    rd = '0;
        endcase
    end

    assign out_valid = ~fifo_empty;
    assign pop       = out_valid & out_ready;
    assign tx_push   = we && (sel == REG_TX);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok   = ~fifo_full | pop;
    assign ovf_event = tx_push & ~push_ok;
    assign ovf_clear = we && (sel == REG_STATUS) && wd[OVF_B];
    assign err_next  = ovf_event | (we && (sel == REG_NONE));

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_push & push_ok),
        .pop   (pop),
        .din   (wd),
        .dout  (out_data),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
            cycles   <= '0;
            err      <= 1'b0;
        end else begin
            err <= err_next;
            // Set wins over a simultaneous clear.
            if (ovf_event) begin
                overflow <= 1'b1;
            end else if (ovf_clear) begin
                overflow <= 1'b0;
            end
            if (we && sel == REG_CYCLES) begin
                cycles <= '0;
            end else begin
                cycles <= cycles + 32'd1;
            end
        end
    end

endmodule
